// File: rtl/peripheral_muldiv.sv
// Memory-mapped iterative multiply/divide peripheral: radix-2 shift-add multiply
// and restoring divide, one bit per clock, signed and unsigned.
module peripheral_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 cs,
  input  logic [4:0]           addr,
  input  logic                 rd,
  input  logic                 wr,
  output logic [2*WIDTH-1:0]   d_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    a_reg, b_reg;
  logic [2*WIDTH-1:0]  result;
  logic [1:0]          mode;
  logic                done, dz;
  logic [WIDTH-1:0]    acc_hi, acc_lo, opnd;
  logic [CW-1:0]       cnt;
  logic                sign_a, sign_b;

  logic                busy, start_go, run_en, fix_en, a_wr, b_wr, ctrl_wr;
  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [WIDTH:0]      mul_sum, div_shift;
  logic [WIDTH-1:0]    div_diff, quo_fix, rem_fix;
  logic                div_ge, neg_res;
  logic [2*WIDTH-1:0]  prod, prod_fix, rdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_wr     = cs & wr & (addr == 5'h04);
    b_wr     = cs & wr & (addr == 5'h08);
    ctrl_wr  = cs & wr & (addr == 5'h0C);
    busy     = (state != IDLE);
    start_go = (state == IDLE) & ctrl_wr & d_in[0];
    run_en   = (state == RUN);
    fix_en   = (state == FIX);
  end

  // Magnitudes are taken at start time using the incoming mode's signed bit.
  always_comb begin
    a_neg     = d_in[1] & a_reg[WIDTH-1];
    b_neg     = d_in[1] & b_reg[WIDTH-1];
    mag_a     = a_neg ? -a_reg : a_reg;
    mag_b     = b_neg ? -b_reg : b_reg;

    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;

    neg_res   = mode[0] & (sign_a ^ sign_b);
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_res ? -prod : prod;
    quo_fix   = neg_res ? -acc_lo : acc_lo;
    rem_fix   = (mode[0] & sign_a) ? -acc_hi : acc_hi;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      5'h04:   rdata = {{WIDTH{1'b0}}, a_reg};
      5'h08:   rdata = {{WIDTH{1'b0}}, b_reg};
      5'h10:   rdata = result;
      5'h14:   rdata = {{(2*WIDTH-3){1'b0}}, dz, busy, done};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      mode   <= '0;
      done   <= 1'b0;
      dz     <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      cnt    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      d_out  <= '0;
    end else begin
      if (cs & rd) d_out <= rdata;
      if (a_wr) a_reg <= d_in;
      if (b_wr) b_reg <= d_in;

      if (start_go) begin
        mode   <= d_in[2:1];
        done   <= 1'b0;
        dz     <= d_in[2] & (b_reg == '0);
        cnt    <= CW'(WIDTH);
        sign_a <= a_reg[WIDTH-1];
        sign_b <= b_reg[WIDTH-1];
        acc_hi <= '0;
        if (d_in[2]) begin
          acc_lo <= mag_a;
          opnd   <= mag_b;
        end else begin
          acc_lo <= mag_b;
          opnd   <= mag_a;
        end
      end

      if (run_en) begin
        cnt <= cnt - CW'(1);
        if (mode[1]) begin
          // Zero divisor always "fits": quotient all ones, remainder ends as dividend.
          acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
        end else begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end

      if (fix_en) begin
        result <= mode[1] ? {rem_fix, quo_fix} : prod_fix;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/peripheral_muldiv.md
# peripheral_muldiv

Memory-mapped iterative multiply/divide peripheral on the processor's chip-select bus. It is the parametrised successor of the fixed 16-bit multiplier peripheral. Operand width is a parameter, and four modes are supported: unsigned/signed multiply and unsigned/signed divide. The core is a radix-2 engine that processes one bit per clock. Software programs the operands, writes a start command, polls status and reads back the result.

## Interface
- `WIDTH`, default 16: operand width in bits; must be ≥4 and even. The result is `2*WIDTH` bits.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `d_in`  in  WIDTH: write data.
- `cs`  in  1: chip select; nothing happens unless high.
- `addr`  in  5: byte register address.
- `rd`  in  1: read strobe, qualified by `cs`.
- `wr`  in  1: write strobe, qualified by `cs`.
- `d_out`  out  2*WIDTH: registered read data.

## Operation
Register map:
- 0x04 `A`: read/write operand; multiplicand or dividend.
- 0x08 `B`: read/write operand; multiplier or divisor.
- 0x0C `CTRL`, write only:
  - bit0 `start`.
  - bits[2:1] `mode`: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
  - Writing with bit0=0 has no effect.
- 0x10 `RESULT`, read only:
  - Multiply: full `2*WIDTH` product.
  - Divide: `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`.
- 0x14 `STATUS`, read only, zero-extended: bit0 `done`, bit1 `busy`, bit2 `dz` (divide by zero).
- Reads of `A`/`B` return the value zero-extended. Unmapped addresses read 0. Writes to read-only or unmapped addresses are ignored.

State machine (IDLE, RUN, FIX):
- **IDLE:** a `CTRL` write with `start`=1 does the following:
  - Latches `mode`.
  - Copies |A| and |B| into working registers. Magnitudes apply for signed modes; raw values otherwise.
  - Records the result sign(s), loads bit counter = `WIDTH`.
  - Clears `done` and `dz`; sets `dz` if mode is divide and B==0.
  - Next state is RUN.
- **RUN:** one iteration per cycle, counter decrements. Next state is FIX after `WIDTH` iterations.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
- **FIX:** applies two's-complement negation to the result, writes `RESULT`, sets `done`=1, and returns to IDLE.
  - Multiply: negate the product if the operand signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Unsigned modes pass through unchanged.
- `busy` = (state != IDLE).
- `done` is sticky until the next accepted start or reset.
- A `start` write while busy is ignored entirely: mode, operands and flags are unchanged.
- `A`/`B` writes while busy are accepted and do not affect the running operation.
- Divide by zero takes normal latency and produces a defined result: quotient = all ones (unsigned) or the natural result of the magnitude algorithm followed by FIX (signed); remainder = A; `dz`=1.
- Signed divide of −2^(WIDTH−1) by −1 wraps: quotient = −2^(WIDTH−1), remainder 0; no flag is raised.
- `cs&rd&wr` in the same cycle: the write is performed, and the read returns the pre-write value.

## Timing
- **Reset:**
  - `d_out`, `A`, `B`, `RESULT`, `mode` and all flags are 0; state is IDLE.
  - Reset during RUN/FIX aborts the operation; `done` stays 0.
- **Writes:** take effect at the rising edge where `cs&wr`.
- **Reads:** `d_out` loads the addressed value at the edge where `cs&rd` and holds it until the next read edge. Data is valid from that edge.
- **Latency:**
  - Start accepted at edge E0.
  - RUN occupies edges E1..E`WIDTH`; FIX occurs at edge E`WIDTH`+1.
  - `done`=1 and `RESULT` are valid after E`WIDTH`+1, i.e. `WIDTH`+1 cycles after start, for every mode.
  - The earliest next start is accepted at E`WIDTH`+2.
- `busy` is high after E0 through E`WIDTH`+1 inclusive, and low after E`WIDTH`+1.
- A `STATUS` read at the FIX edge returns the pre-FIX value (busy=1, done=0).

## Test plan
All scenarios use WIDTH=16.
- **Unsigned multiply:** A=0x0005, B=0x000F, start mode 00. Required: STATUS=0x1 exactly 17 cycles after start; RESULT=0x0000004B. Check busy during the run.
- **Signed multiply:** A=0xFFFD (−3), B=0x0007, mode 01. Required: RESULT=0xFFFFFFEB; A=0x8000 × B=0x8000 gives 0x40000000.
- **Unsigned divide:** A=100, B=7, mode 10. Required: RESULT=0x0002000E.
- **Signed divide:** A=0xFFF9 (−7), B=2, mode 11. Required: RESULT=0xFFFFFFFD (rem −1, quot −3). Also 0x8000/0xFFFF gives 0x00008000.
- **Divide by zero:** A=0x04D2, B=0, mode 10. Required: RESULT=0x04D2FFFF and STATUS=0x5 after 17 cycles; a following valid start clears `dz`.
- **Boundaries:**
  - A start written 5 cycles into a run is ignored, and the original result is unchanged.
  - An A-write mid-run does not alter the result.
  - `rst` pulsed mid-run gives STATUS=0, RESULT=0 and d_out=0.
  - A simultaneous rd+wr to `A` returns the old A.
